// File: rtl/jogo_pkg.sv
// Shared definitions for the game-round controller: state codes, the
// pattern width and the default pattern table used by pattern_rom.
package jogo_pkg;

  localparam int PADRAO_W  = 28;
  localparam int N_PADROES = 8;

  localparam logic [2:0] EST_IDLE    = 3'd0;
  localparam logic [2:0] EST_CARREGA = 3'd1;
  localparam logic [2:0] EST_ESPERA  = 3'd2;
  localparam logic [2:0] EST_AVALIA  = 3'd3;
  localparam logic [2:0] EST_FIM     = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = EST_IDLE,
    CARREGA = EST_CARREGA,
    ESPERA  = EST_ESPERA,
    AVALIA  = EST_AVALIA,
    FIM     = EST_FIM
  } estado_t;

  localparam logic [PADRAO_W-1:0] PADRAO_0 = 28'h1234567;
  localparam logic [PADRAO_W-1:0] PADRAO_1 = 28'h7654321;
  localparam logic [PADRAO_W-1:0] PADRAO_2 = 28'h0ABCDEF;
  localparam logic [PADRAO_W-1:0] PADRAO_3 = 28'h0F0F0F0;
  localparam logic [PADRAO_W-1:0] PADRAO_4 = 28'h5A5A5A5;
  localparam logic [PADRAO_W-1:0] PADRAO_5 = 28'hA5A5A5A;
  localparam logic [PADRAO_W-1:0] PADRAO_6 = 28'h3C3C3C3;
  localparam logic [PADRAO_W-1:0] PADRAO_7 = 28'hFEDCBA9;

  // Table lookup; indices past the table wrap so any round count is legal.
  function automatic logic [PADRAO_W-1:0] padrao_default(input int unsigned idx);
    logic [PADRAO_W-1:0] word;
    case (idx % N_PADROES)
      0:       word = PADRAO_0;
      1:       word = PADRAO_1;
      2:       word = PADRAO_2;
      3:       word = PADRAO_3;
      4:       word = PADRAO_4;
      5:       word = PADRAO_5;
      6:       word = PADRAO_6;
      default: word = PADRAO_7;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Combinational pattern ROM: one 28-bit expected play per round index,
// with contents taken from the default table in jogo_pkg.
module pattern_rom
  import jogo_pkg::*;
#(
  parameter int N_RODADAS = 8,
  localparam int W_IDX = (N_RODADAS > 1) ? $clog2(N_RODADAS) : 1
) (
  input  logic [W_IDX-1:0]    index_i,
  output logic [PADRAO_W-1:0] word_o
);

  // Pure table lookup, no state.
  always_comb begin
    word_o = padrao_default(32'(index_i));
  end

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: walks the play analyser through a match, loading
// the pattern for each round, tallying score and lives, declaring win/loss.
// Optional per-round timeout enabled by defining ROUND_SEQUENCER_TIMEOUT_EN.
module round_sequencer
  import jogo_pkg::*;
#(
  parameter int N_RODADAS      = 8,
  parameter int VIDAS_INI      = 3,
  parameter int W_PONTOS       = 8,
  parameter int TIMEOUT_CICLOS = 50000000,
  localparam int W_ROD = $clog2(N_RODADAS),
  localparam int W_VID = $clog2(VIDAS_INI + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic                pronto_comparacao,
  input  logic                acertou,
  output logic [PADRAO_W-1:0] expected,
  output logic [W_ROD-1:0]    rodada,
  output logic [W_PONTOS-1:0] pontos,
  output logic [W_VID-1:0]    vidas,
  output logic                jogando,
  output logic                fim_jogo,
  output logic                ganhou,
  output logic                estourou,
  output logic [2:0]          db_estado
);

  // Reject parameter sets the controller cannot represent.
  if (N_RODADAS < 2 || VIDAS_INI < 1 || W_PONTOS < 1 || TIMEOUT_CICLOS < 2) begin : g_param_check
    $error("round_sequencer: illegal parameter set");
  end

  localparam logic [W_ROD-1:0] ULTIMA_RODADA = W_ROD'(N_RODADAS - 1);
  localparam logic [W_VID-1:0] VIDAS_CARGA   = W_VID'(VIDAS_INI);

  estado_t             estado_q;
  logic [PADRAO_W-1:0] expected_q;
  logic [W_ROD-1:0]    rodada_q;
  logic [W_PONTOS-1:0] pontos_q;
  logic [W_VID-1:0]    vidas_q;
  logic                jogando_q;
  logic                fim_jogo_q;
  logic                ganhou_q;
  logic                hit_q;
  logic [W_PONTOS-1:0] pontos_d;
  logic [PADRAO_W-1:0] rom_word;

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT_CICLOS - 1);
  logic [TIMER_W-1:0] timer_q;
  logic               estourou_q;
`endif

  pattern_rom #(
    .N_RODADAS(N_RODADAS)
  ) u_rom (
    .index_i(rodada_q),
    .word_o (rom_word)
  );

  // Score increment saturates at all-ones instead of wrapping.
  assign pontos_d = (&pontos_q) ? pontos_q : pontos_q + 1'b1;

  // Match FSM; all outputs are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= IDLE;
      expected_q <= '0;
      rodada_q   <= '0;
      pontos_q   <= '0;
      vidas_q    <= '0;
      jogando_q  <= 1'b0;
      fim_jogo_q <= 1'b0;
      ganhou_q   <= 1'b0;
      hit_q      <= 1'b0;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
      timer_q    <= '0;
      estourou_q <= 1'b0;
`endif
    end else begin
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
      estourou_q <= 1'b0;
`endif
      case (estado_q)
        IDLE, FIM: begin
          if (iniciar) begin
            rodada_q   <= '0;
            pontos_q   <= '0;
            vidas_q    <= VIDAS_CARGA;
            ganhou_q   <= 1'b0;
            fim_jogo_q <= 1'b0;
            estado_q   <= CARREGA;
          end
        end
        CARREGA: begin
          expected_q <= rom_word;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
          timer_q    <= '0;
`endif
          jogando_q  <= 1'b1;
          estado_q   <= ESPERA;
        end
        ESPERA: begin
          if (pronto_comparacao) begin
            hit_q     <= acertou;
            jogando_q <= 1'b0;
            estado_q  <= AVALIA;
          end
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
          else if (timer_q == TIMER_MAX) begin
            hit_q      <= 1'b0;
            estourou_q <= 1'b1;
            jogando_q  <= 1'b0;
            estado_q   <= AVALIA;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        AVALIA: begin
          if (hit_q) begin
            pontos_q <= pontos_d;
            if (rodada_q == ULTIMA_RODADA) begin
              ganhou_q   <= 1'b1;
              fim_jogo_q <= 1'b1;
              estado_q   <= FIM;
            end else begin
              rodada_q <= rodada_q + 1'b1;
              estado_q <= CARREGA;
            end
          end else begin
            vidas_q <= vidas_q - 1'b1;
            if (vidas_q == W_VID'(1)) begin
              ganhou_q   <= 1'b0;
              fim_jogo_q <= 1'b1;
              estado_q   <= FIM;
            end else begin
              estado_q <= CARREGA;
            end
          end
        end
        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  assign expected  = expected_q;
  assign rodada    = rodada_q;
  assign pontos    = pontos_q;
  assign vidas     = vidas_q;
  assign jogando   = jogando_q;
  assign fim_jogo  = fim_jogo_q;
  assign ganhou    = ganhou_q;
  assign db_estado = estado_q;
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  assign estourou  = estourou_q;
`else
  assign estourou  = 1'b0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// Self-checking bench for round_sequencer (3 rounds, 2 lives, 10-cycle
// timeout). Expected patterns are queued as stimulus is driven and popped
// when the controller reaches ESPERA. Timeout scenarios follow
// ROUND_SEQUENCER_TIMEOUT_EN.
module tb_round_sequencer;

  localparam int NR = 3;
  localparam int VI = 2;
  localparam int TO = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        iniciar = 1'b0;
  logic        pronto = 1'b0;
  logic        acertou = 1'b0;
  logic [27:0] expected;
  logic [1:0]  rodada;
  logic [7:0]  pontos;
  logic [1:0]  vidas;
  logic        jogando;
  logic        fimJogo;
  logic        ganhou;
  logic        estourou;
  logic [2:0]  dbEstado;

  int          nChecks = 0;
  int          nFail = 0;
  logic [27:0] expQ[$];
  logic [27:0] romTb[0:2];
  logic [27:0] e;
  int          mRod, mPts, mVid;
  bit          mFim, mGan;

  // Free-running clock.
  always #5 clock = ~clock;

  round_sequencer #(
    .N_RODADAS(NR),
    .VIDAS_INI(VI),
    .W_PONTOS(8),
    .TIMEOUT_CICLOS(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .pronto_comparacao(pronto),
    .acertou(acertou),
    .expected(expected),
    .rodada(rodada),
    .pontos(pontos),
    .vidas(vidas),
    .jogando(jogando),
    .fim_jogo(fimJogo),
    .ganhou(ganhou),
    .estourou(estourou),
    .db_estado(dbEstado)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyReset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    expQ.delete();
  endtask

  task automatic pulseIniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic pulsePronto(input logic a);
    pronto = 1'b1;
    acertou = a;
    tick();
    pronto = 1'b0;
    acertou = 1'b0;
  endtask

  task automatic modelStart();
    mRod = 0; mPts = 0; mVid = VI; mFim = 0; mGan = 0;
    expQ.push_back(romTb[0]);
  endtask

  task automatic modelResult(input bit hit);
    if (hit) begin
      if (mPts < 255) mPts++;
      if (mRod == NR - 1) begin
        mFim = 1; mGan = 1;
      end else begin
        mRod++;
        expQ.push_back(romTb[mRod]);
      end
    end else begin
      mVid--;
      if (mVid == 0) begin
        mFim = 1; mGan = 0;
      end else begin
        expQ.push_back(romTb[mRod]);
      end
    end
  endtask

  task automatic test_reset();
    applyReset(2);
    nChecks++;
    if (dbEstado !== 3'd0) begin nFail++; $display("[TB] FAIL reset_state: got %0d expected 0", dbEstado); end
    nChecks++;
    if ({expected, rodada, pontos, vidas, jogando, fimJogo, ganhou, estourou} !== '0) begin
      nFail++; $display("[TB] FAIL reset_outputs: got exp=%h rod=%0d pts=%0d vid=%0d jog=%b fim=%b gan=%b est=%b expected all 0",
                        expected, rodada, pontos, vidas, jogando, fimJogo, ganhou, estourou);
    end
    pulseIniciar();
    modelStart();
    tick();
    nChecks++;
    if (jogando !== 1'b1 || vidas !== 2'd2) begin nFail++; $display("[TB] FAIL start_latency: got jog=%b vid=%0d expected jog=1 vid=2", jogando, vidas); end
    nChecks++;
    if (expQ.size() == 0) begin nFail++; $display("[TB] FAIL start_pattern: scoreboard empty, got %h", expected); end
    else begin
      e = expQ.pop_front();
      if (expected !== e) begin nFail++; $display("[TB] FAIL start_pattern: got %h expected %h", expected, e); end
    end
  endtask

  task automatic test_perfect_match();
    for (int k = 0; k < NR; k++) begin
      pulsePronto(1'b1);
      modelResult(1'b1);
      if (!mFim) begin
        tick(2);
        nChecks++;
        if (rodada !== 2'(mRod) || pontos !== 8'(mPts) || jogando !== 1'b1) begin
          nFail++; $display("[TB] FAIL perfect_step%0d: got rod=%0d pts=%0d jog=%b expected rod=%0d pts=%0d jog=1", k, rodada, pontos, jogando, mRod, mPts);
        end
        nChecks++;
        if (expQ.size() == 0) begin nFail++; $display("[TB] FAIL perfect_pattern%0d: scoreboard empty, got %h", k, expected); end
        else begin
          e = expQ.pop_front();
          if (expected !== e) begin nFail++; $display("[TB] FAIL perfect_pattern%0d: got %h expected %h", k, expected, e); end
        end
      end else begin
        tick();
        nChecks++;
        if (fimJogo !== 1'b1 || ganhou !== 1'b1 || pontos !== 8'd3 || rodada !== 2'd2) begin
          nFail++; $display("[TB] FAIL perfect_end: got fim=%b gan=%b pts=%0d rod=%0d expected fim=1 gan=1 pts=3 rod=2", fimJogo, ganhou, pontos, rodada);
        end
      end
    end
  endtask

  task automatic test_pronto_in_fim();
    pulsePronto(1'b0);
    tick(3);
    nChecks++;
    if (dbEstado !== 3'd4 || fimJogo !== 1'b1 || ganhou !== 1'b1 || pontos !== 8'd3 || vidas !== 2'd2) begin
      nFail++; $display("[TB] FAIL fim_hold: got st=%0d fim=%b gan=%b pts=%0d vid=%0d expected st=4 fim=1 gan=1 pts=3 vid=2",
                        dbEstado, fimJogo, ganhou, pontos, vidas);
    end
  endtask

  task automatic test_loss_retry();
    pulseIniciar();
    modelStart();
    tick();
    nChecks++;
    if (pontos !== 8'd0 || vidas !== 2'd2 || fimJogo !== 1'b0 || dbEstado !== 3'd2) begin
      nFail++; $display("[TB] FAIL restart_from_fim: got pts=%0d vid=%0d fim=%b st=%0d expected pts=0 vid=2 fim=0 st=2", pontos, vidas, fimJogo, dbEstado);
    end
    if (expQ.size() > 0) e = expQ.pop_front();
    pulsePronto(1'b1);
    modelResult(1'b1);
    tick(2);
    nChecks++;
    if (expQ.size() == 0) begin nFail++; $display("[TB] FAIL loss_round1_pattern: scoreboard empty, got %h", expected); end
    else begin
      e = expQ.pop_front();
      if (expected !== e || rodada !== 2'd1) begin nFail++; $display("[TB] FAIL loss_round1_pattern: got %h rod=%0d expected %h rod=1", expected, rodada, e); end
    end
    pulsePronto(1'b0);
    modelResult(1'b0);
    tick(2);
    nChecks++;
    if (expQ.size() == 0) begin nFail++; $display("[TB] FAIL retry_pattern: scoreboard empty, got %h", expected); end
    else begin
      e = expQ.pop_front();
      if (expected !== e || expected !== 28'h7654321) begin nFail++; $display("[TB] FAIL retry_pattern: got %h expected %h", expected, e); end
    end
    nChecks++;
    if (vidas !== 2'(mVid) || rodada !== 2'd1) begin nFail++; $display("[TB] FAIL retry_lives: got vid=%0d rod=%0d expected vid=%0d rod=1", vidas, rodada, mVid); end
    pulsePronto(1'b0);
    modelResult(1'b0);
    tick();
    nChecks++;
    if (fimJogo !== 1'b1 || ganhou !== 1'b0 || pontos !== 8'd1 || vidas !== 2'd0) begin
      nFail++; $display("[TB] FAIL loss_end: got fim=%b gan=%b pts=%0d vid=%0d expected fim=1 gan=0 pts=1 vid=0", fimJogo, ganhou, pontos, vidas);
    end
  endtask

  task automatic test_ignored_iniciar();
    pulseIniciar();
    modelStart();
    tick();
    if (expQ.size() > 0) e = expQ.pop_front();
    pulseIniciar();
    tick(2);
    nChecks++;
    if (dbEstado !== 3'd2 || rodada !== 2'd0 || jogando !== 1'b1 || expected !== romTb[0]) begin
      nFail++; $display("[TB] FAIL iniciar_in_espera: got st=%0d rod=%0d jog=%b exp=%h expected st=2 rod=0 jog=1 exp=%h",
                        dbEstado, rodada, jogando, expected, romTb[0]);
    end
  endtask

`ifdef ROUND_SEQUENCER_TIMEOUT_EN
  task automatic test_timeout();
    int nPulse;
    int pulseAt;
    nPulse = 0;
    pulseAt = -1;
    applyReset(1);
    pulseIniciar();
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (estourou === 1'b1) begin
        nPulse++;
        if (pulseAt < 0) pulseAt = i;
      end
    end
    nChecks++;
    if (nPulse !== 1 || pulseAt !== TO - 1) begin nFail++; $display("[TB] FAIL timeout_pulse: got %0d pulses at %0d expected 1 at %0d", nPulse, pulseAt, TO - 1); end
    nChecks++;
    if (vidas !== 2'd1 || rodada !== 2'd0 || pontos !== 8'd0) begin
      nFail++; $display("[TB] FAIL timeout_miss: got vid=%0d rod=%0d pts=%0d expected vid=1 rod=0 pts=0", vidas, rodada, pontos);
    end
  endtask

  task automatic test_collision();
    applyReset(1);
    pulseIniciar();
    tick();
    tick(TO - 1);
    pronto = 1'b1;
    acertou = 1'b1;
    tick();
    pronto = 1'b0;
    acertou = 1'b0;
    nChecks++;
    if (estourou !== 1'b0 || dbEstado !== 3'd3) begin nFail++; $display("[TB] FAIL collision_estourou: got est=%b st=%0d expected est=0 st=3", estourou, dbEstado); end
    tick();
    nChecks++;
    if (pontos !== 8'd1 || rodada !== 2'd1 || vidas !== 2'd2) begin
      nFail++; $display("[TB] FAIL collision_hit: got pts=%0d rod=%0d vid=%0d expected pts=1 rod=1 vid=2", pontos, rodada, vidas);
    end
  endtask
`else
  task automatic test_no_timeout();
    int dropped;
    dropped = 0;
    applyReset(1);
    pulseIniciar();
    tick();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (jogando !== 1'b1 || estourou !== 1'b0) dropped++;
    end
    nChecks++;
    if (dropped !== 0) begin nFail++; $display("[TB] FAIL no_timeout_wait: got %0d bad cycles expected 0", dropped); end
  endtask
`endif

  task automatic test_reset_mid();
    applyReset(1);
    pulseIniciar();
    tick();
    pulsePronto(1'b1);
    tick(2);
    nChecks++;
    if (rodada !== 2'd1 || pontos !== 8'd1 || dbEstado !== 3'd2) begin
      nFail++; $display("[TB] FAIL mid_setup: got rod=%0d pts=%0d st=%0d expected rod=1 pts=1 st=2", rodada, pontos, dbEstado);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nChecks++;
    if (dbEstado !== 3'd0 || pontos !== 8'd0 || rodada !== 2'd0 || expected !== 28'd0 || jogando !== 1'b0) begin
      nFail++; $display("[TB] FAIL mid_reset: got st=%0d pts=%0d rod=%0d exp=%h jog=%b expected all 0",
                        dbEstado, pontos, rodada, expected, jogando);
    end
    tick(3);
    nChecks++;
    if (dbEstado !== 3'd0 || vidas !== 2'd0) begin nFail++; $display("[TB] FAIL mid_no_pending: got st=%0d vid=%0d expected st=0 vid=0", dbEstado, vidas); end
  endtask

  // Bound on total run time in case the design stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence.
  initial begin
    romTb[0] = 28'h1234567;
    romTb[1] = 28'h7654321;
    romTb[2] = 28'h0ABCDEF;
    test_reset();
    test_perfect_match();
    test_pronto_in_fim();
    test_loss_retry();
    test_ignored_iniciar();
`ifdef ROUND_SEQUENCER_TIMEOUT_EN
    test_timeout();
    test_collision();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/round_sequencer.md
Name: round_sequencer

Overview:
- Game-round controller that sequences the play analyser through a complete match.
- Per round it loads the 28-bit `expected` pattern from a pattern ROM, then waits for the analyser's comparison result.
- It updates the round index, score and lives, and declares win or loss.
- Sits between the top-level game FSM and the play analyser; drives `expected` and consumes `pronto_comparacao`/`acertou`.

Parameters:
- N_RODADAS, 8, number of rounds in a match (≥2).
- VIDAS_INI, 3, lives loaded at match start (≥1).
- W_PONTOS, 8, score counter width.
- TIMEOUT_CICLOS, 50000000, cycles allowed per round before a forced miss (used only with TIMEOUT_EN).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge where reset=1.
- iniciar  in  1  single-cycle start pulse (already edge-detected upstream).
- pronto_comparacao  in  1  single-cycle pulse from analyser: comparison done.
- acertou  in  1  comparison result; sampled only when pronto_comparacao=1.
- expected  out  28  pattern for current round, registered.
- rodada  out  $clog2(N_RODADAS)  current round index.
- pontos  out  W_PONTOS  score.
- vidas  out  $clog2(VIDAS_INI+1)  remaining lives.
- jogando  out  1  high while waiting for the player (ESPERA).
- fim_jogo  out  1  high in FIM.
- ganhou  out  1  valid when fim_jogo=1: 1=win, 0=loss.
- estourou  out  1  one-cycle pulse when a round times out (tied 0 without TIMEOUT_EN).
- db_estado  out  3  state code for debug display.

Behaviour:
- Reset: state=IDLE, and every output clears to 0 on the next edge: expected, rodada, pontos, vidas, jogando, fim_jogo, ganhou, estourou.
- Reset mid-round aborts with no pending update.
- States and codes: IDLE=0, CARREGA=1, ESPERA=2, AVALIA=3, FIM=4; unused codes go to IDLE.
- IDLE: iniciar → CARREGA; rodada←0, pontos←0, vidas←VIDAS_INI, ganhou←0.
- CARREGA (1 cycle): expected←rom[rodada]; timeout counter←0; → ESPERA.
- Latency: iniciar to expected valid is 2 edges.
- ESPERA: jogando=1.
  - pronto_comparacao=1 → capture acertou into hit flag; → AVALIA.
  - Timeout → hit flag←0, estourou pulses; → AVALIA.
  - If pronto_comparacao and timeout occur in the same cycle, pronto_comparacao wins and estourou stays 0.
- AVALIA (1 cycle), hit:
  - pontos←pontos+1, saturating at all-ones.
  - If rodada==N_RODADAS-1 → FIM, ganhou←1.
  - Otherwise rodada←rodada+1 → CARREGA.
- AVALIA (1 cycle), miss:
  - vidas←vidas-1.
  - If vidas was 1 → FIM, ganhou←0.
  - Otherwise rodada unchanged → CARREGA (retry the same pattern).
- FIM: fim_jogo=1; pontos, rodada, vidas and ganhou hold.
  - iniciar → behaves exactly as in IDLE (new match) → CARREGA.
- iniciar is ignored in CARREGA, ESPERA and AVALIA.
- pronto_comparacao is ignored outside ESPERA.
- expected holds its value between CARREGA loads, and is cleared only by reset.

Optional Feature:
- Macro: ROUND_SEQUENCER_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CICLOS) bits increments every cycle in ESPERA.
  - At count TIMEOUT_CICLOS-1 with no pronto_comparacao, the round is forced to a miss and estourou=1 for exactly one cycle, on the ESPERA→AVALIA transition.
- Undefined:
  - No counter; ESPERA waits indefinitely.
  - estourou is constant 0.

Decomposition:
- Shared package `jogo_pkg`:
  - State-code localparams (IDLE..FIM, 3 bits).
  - 28-bit pattern width constant.
  - Default pattern table constants.
- One sub-module, `pattern_rom`:
  - Combinational.
  - Parameter N_RODADAS; input index, output 28-bit word.
  - Contents are taken from `jogo_pkg`.

Test Plan (N_RODADAS=3, VIDAS_INI=2, TIMEOUT_CICLOS=10, rom={28'h1234567, 28'h7654321, 28'h0ABCDEF}):
- Reset held 2 cycles, then released → db_estado=0, all outputs 0; iniciar pulse → 2 edges later expected=28'h1234567, jogando=1, vidas=2.
- Perfect match: three pronto_comparacao pulses with acertou=1 → rodada steps 0→1→2, pontos=3, fim_jogo=1, ganhou=1.
- Loss with retry:
  - Round 0 hit; two misses on round 1 → expected stays 28'h7654321 after the first miss, vidas=1.
  - After the second miss: fim_jogo=1, ganhou=0, pontos=1.
- Timeout (TIMEOUT_EN): no pronto for 10 cycles in ESPERA → estourou high exactly 1 cycle, vidas 2→1, rodada stays 0. Same run without the macro → jogando stays 1 for 1000 cycles.
- Collision and ignored inputs:
  - pronto_comparacao=1 with acertou=1 on the timeout cycle → hit, estourou=0.
  - iniciar asserted in ESPERA → no effect.
  - pronto_comparacao in FIM → no effect.
- Reset mid-ESPERA in round 1 → next edge: db_estado=0, pontos=0, rodada=0. In FIM, iniciar restarts the match with pontos=0 and vidas=2.
